// File: rtl/cube_edge_scheduler_if.sv
// rtl/cube_edge_scheduler_if.sv - frame, geometry and line-engine signals of the cube edge scheduler
interface cube_edge_scheduler_if;
    logic        frame_start;
    logic        geo_valid;
    logic [10:0] geo_xline;
    logic [10:0] geo_xdiag;
    logic [9:0]  geo_ydiag;
    logic        line_start;
    logic [10:0] line_x0;
    logic [10:0] line_x1;
    logic [9:0]  line_y0;
    logic [9:0]  line_y1;
    logic        line_done;
    logic [3:0]  edge_id;
    logic        busy;
    logic        frame_done;
    logic [8:0]  edges_ok;
    logic        timeout_err;
    logic        overrun;

    modport master (
        input  frame_start, geo_valid, geo_xline, geo_xdiag, geo_ydiag, line_done,
        output line_start, line_x0, line_x1, line_y0, line_y1, edge_id,
               busy, frame_done, edges_ok, timeout_err, overrun
    );

    modport slave (
        output frame_start, geo_valid, geo_xline, geo_xdiag, geo_ydiag, line_done,
        input  line_start, line_x0, line_x1, line_y0, line_y1, edge_id,
               busy, frame_done, edges_ok, timeout_err, overrun
    );
endinterface

// File: rtl/cube_edge_scheduler.sv
// rtl/cube_edge_scheduler.sv - issues the nine isometric cube edges to one shared line engine per frame
module cube_edge_scheduler #(
    parameter logic [10:0] X_OFFSET   = 11'd400,
    parameter logic [9:0]  Y_OFFSET   = 10'd200,
    parameter logic [10:0] XLINE_INIT = 11'd120,
    parameter logic [10:0] XDIAG_INIT = 11'd50,
    parameter logic [9:0]  YDIAG_INIT = 10'd90,
    parameter int          TIMEOUT    = 2048
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    cube_edge_scheduler_if.master i_bus
);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t           r_state, w_next_state;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [10:0]      r_pend_xl, r_pend_xd, r_act_xl, r_act_xd;
    logic [9:0]       r_pend_yd, r_act_yd;
    logic [10:0]      r_x0, r_x1;
    logic [9:0]       r_y0, r_y1;
    logic [3:0]       r_edge_id;
    logic [8:0]       r_edges_ok;
    logic             r_timeout_err, r_overrun;

    logic             w_is_load, w_last_edge, w_done_ev, w_timeout, w_latch_ep;
    logic             w_line_start, w_busy, w_frame_done;
    logic [10:0]      w_xl, w_xd;
    logic [9:0]       w_yd, w_yd2;
    logic [3:0]       w_issue_idx;
    logic [2:0]       w_src, w_dst;
    logic [10:0]      w_vx [7];
    logic [9:0]       w_vy [7];

    assign w_is_load   = (r_state == S_LOAD);
    assign w_last_edge = (r_idx == 4'd8);
    assign w_done_ev   = (r_state == S_WAIT) && i_bus.line_done;
    assign w_timeout   = (r_state == S_WAIT) && !i_bus.line_done && (r_cnt == CNT_LAST);
    assign w_latch_ep  = w_is_load || ((r_state == S_NEXT) && !w_last_edge);

    // In LOAD the active registers are still being written, so the first edge reads pending directly.
    assign w_xl        = w_is_load ? r_pend_xl : r_act_xl;
    assign w_xd        = w_is_load ? r_pend_xd : r_act_xd;
    assign w_yd        = w_is_load ? r_pend_yd : r_act_yd;
    assign w_yd2       = {w_yd[8:0], 1'b0};
    assign w_issue_idx = w_is_load ? 4'd0 : r_idx + 4'd1;

    always_comb begin
        w_vx[0] = X_OFFSET;               w_vy[0] = Y_OFFSET;
        w_vx[1] = X_OFFSET + w_xl;        w_vy[1] = Y_OFFSET;
        w_vx[2] = X_OFFSET + w_xl + w_xd; w_vy[2] = Y_OFFSET + w_yd;
        w_vx[3] = X_OFFSET + w_xl;        w_vy[3] = Y_OFFSET + w_yd2;
        w_vx[4] = X_OFFSET;               w_vy[4] = Y_OFFSET + w_yd2;
        w_vx[5] = X_OFFSET - w_xd;        w_vy[5] = Y_OFFSET + w_yd;
        w_vx[6] = X_OFFSET + w_xd;        w_vy[6] = Y_OFFSET + w_yd;
    end

    always_comb begin
        w_src = 3'd6;
        w_dst = 3'd2;
        case (w_issue_idx)
            4'd0:    begin w_src = 3'd0; w_dst = 3'd1; end
            4'd1:    begin w_src = 3'd1; w_dst = 3'd2; end
            4'd2:    begin w_src = 3'd2; w_dst = 3'd3; end
            4'd3:    begin w_src = 3'd3; w_dst = 3'd4; end
            4'd4:    begin w_src = 3'd5; w_dst = 3'd4; end
            4'd5:    begin w_src = 3'd0; w_dst = 3'd5; end
            4'd6:    begin w_src = 3'd0; w_dst = 3'd6; end
            4'd7:    begin w_src = 3'd6; w_dst = 3'd4; end
            default: begin w_src = 3'd6; w_dst = 3'd2; end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_line_start = 1'b0;
        w_busy       = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_bus.frame_start) w_next_state = S_LOAD;
            end
            S_LOAD:  w_next_state = S_ISSUE;
            S_ISSUE: begin
                w_line_start = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_ev || w_timeout) w_next_state = S_NEXT;
            end
            S_NEXT:  w_next_state = w_last_edge ? S_DONE : S_ISSUE;
            S_DONE: begin
                w_frame_done = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx         <= 4'd0;
            r_cnt         <= '0;
            r_pend_xl     <= XLINE_INIT;
            r_pend_xd     <= XDIAG_INIT;
            r_pend_yd     <= YDIAG_INIT;
            r_act_xl      <= XLINE_INIT;
            r_act_xd      <= XDIAG_INIT;
            r_act_yd      <= YDIAG_INIT;
            r_x0          <= 11'd0;
            r_x1          <= 11'd0;
            r_y0          <= 10'd0;
            r_y1          <= 10'd0;
            r_edge_id     <= 4'd0;
            r_edges_ok    <= 9'd0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (i_bus.geo_valid) begin
                r_pend_xl <= i_bus.geo_xline;
                r_pend_xd <= i_bus.geo_xdiag;
                r_pend_yd <= i_bus.geo_ydiag;
            end
            case (r_state)
                S_LOAD: begin
                    r_act_xl      <= r_pend_xl;
                    r_act_xd      <= r_pend_xd;
                    r_act_yd      <= r_pend_yd;
                    r_idx         <= 4'd0;
                    r_edges_ok    <= 9'd0;
                    r_timeout_err <= 1'b0;
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done_ev)      r_edges_ok[r_idx] <= 1'b1;
                    else if (w_timeout) r_timeout_err     <= 1'b1;
                end
                S_NEXT: begin
                    if (!w_last_edge) r_idx <= r_idx + 4'd1;
                end
                default: ;
            endcase
            // Endpoints change only on entry to ISSUE so the engine can sample them any time before the next start.
            if (w_latch_ep) begin
                r_x0      <= w_vx[w_src];
                r_y0      <= w_vy[w_src];
                r_x1      <= w_vx[w_dst];
                r_y1      <= w_vy[w_dst];
                r_edge_id <= w_issue_idx;
            end
            if (w_is_load)                                  r_overrun <= i_bus.frame_start;
            else if (i_bus.frame_start && r_state != S_IDLE) r_overrun <= 1'b1;
        end
    end

    assign i_bus.line_start  = w_line_start;
    assign i_bus.busy        = w_busy;
    assign i_bus.frame_done  = w_frame_done;
    assign i_bus.line_x0     = r_x0;
    assign i_bus.line_x1     = r_x1;
    assign i_bus.line_y0     = r_y0;
    assign i_bus.line_y1     = r_y1;
    assign i_bus.edge_id     = r_edge_id;
    assign i_bus.edges_ok    = r_edges_ok;
    assign i_bus.timeout_err = r_timeout_err;
    assign i_bus.overrun     = r_overrun;
endmodule

// File: tb/tb_cube_edge_scheduler.sv
// tb/tb_cube_edge_scheduler.sv - directed scoreboard bench for cube_edge_scheduler
module tb_cube_edge_scheduler;
    localparam int TIMEOUT = 2048;
    localparam int SRC [9] = '{0, 1, 2, 3, 5, 0, 0, 6, 6};
    localparam int DST [9] = '{1, 2, 3, 4, 4, 5, 6, 4, 2};

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [45:0] sb [$];
    logic [45:0] obs_item [9];
    logic [10:0] m_pend_xl, m_pend_xd, m_act_xl, m_act_xd;
    logic [9:0]  m_pend_yd, m_act_yd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cube_edge_scheduler_if bus ();
    cube_edge_scheduler #(.TIMEOUT(TIMEOUT)) dut (.i_clk(clk), .i_rst_n(rst_n), .i_bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [45:0] exp_edge(input int e, input logic [10:0] xl,
                                              input logic [10:0] xd, input logic [9:0] yd);
        logic [10:0] vx [7];
        logic [9:0]  vy [7];
        vx[0] = 11'd400;           vy[0] = 10'd200;
        vx[1] = 11'd400 + xl;      vy[1] = 10'd200;
        vx[2] = 11'd400 + xl + xd; vy[2] = 10'd200 + yd;
        vx[3] = 11'd400 + xl;      vy[3] = 10'd200 + yd + yd;
        vx[4] = 11'd400;           vy[4] = 10'd200 + yd + yd;
        vx[5] = 11'd400 - xd;      vy[5] = 10'd200 + yd;
        vx[6] = 11'd400 + xd;      vy[6] = 10'd200 + yd;
        return {4'(e), vx[SRC[e]], vy[SRC[e]], vx[DST[e]], vy[DST[e]]};
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, " ctrl outs"}, {bus.line_start, bus.busy, bus.frame_done, bus.timeout_err, bus.overrun}, 5'd0);
        check({name, " edges_ok"}, bus.edges_ok, 9'd0);
        check({name, " edge_id"}, bus.edge_id, 4'd0);
        check({name, " endpoints"}, {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, 42'd0);
    endtask

    task automatic idle_check(input string name, input int n);
        int starts;
        int busy_cnt;
        starts = 0;
        busy_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.line_start) starts++;
            if (bus.busy) busy_cnt++;
        end
        check({name, " no line_start"}, starts, 0);
        check({name, " not busy"}, busy_cnt, 0);
    endtask

    task automatic model_reset();
        m_pend_xl = 11'd120; m_pend_xd = 11'd50; m_pend_yd = 10'd90;
        m_act_xl  = 11'd120; m_act_xd  = 11'd50; m_act_yd  = 10'd90;
        sb.delete();
    endtask

    // Engine answers 3 cycles after each start; hooks fire in the first WAIT cycle of the named edge.
    task automatic run_frame(input string name, input int skip_edge, input int geo_edge,
                             input int fs_edge, input int early_edge, input int rst_edge);
        int t_fs, exp_start, done_cyc, cur_start, cur_edge, n_fd, fd_cyc;
        logic [8:0]  exp_ok;
        logic [45:0] item, got;
        bit aborted, finished, exp_over;
        @(negedge clk);
        check({name, " idle before frame"}, bus.busy, 1'b0);
        bus.frame_start = 1'b1;
        t_fs = cyc;
        m_act_xl = m_pend_xl; m_act_xd = m_pend_xd; m_act_yd = m_pend_yd;
        for (int e = 0; e < 9; e++) sb.push_back(exp_edge(e, m_act_xl, m_act_xd, m_act_yd));
        exp_start = t_fs + 2; done_cyc = -1; cur_start = -100; cur_edge = -1;
        n_fd = 0; fd_cyc = -1; exp_ok = 9'd0; aborted = 0; finished = 0; exp_over = 0;
        for (int k = 0; k < TIMEOUT + 300 && !finished; k++) begin
            @(negedge clk);
            bus.frame_start = 1'b0;
            bus.geo_valid   = 1'b0;
            bus.line_done   = 1'b0;
            if (cyc == t_fs + 1) check({name, " busy rises"}, bus.busy, 1'b1);
            if (bus.line_start) begin
                check({name, " start cycle"}, cyc, exp_start);
                cur_edge++;
                cur_start = cyc;
                if (cur_edge == 0)
                    check({name, " flags cleared"}, {bus.edges_ok, bus.timeout_err, bus.overrun}, 11'd0);
                got = {bus.edge_id, bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1};
                if (cur_edge < 9) obs_item[cur_edge] = got;
                if (sb.size() > 0) begin
                    item = sb.pop_front();
                    check({name, " edge endpoints"}, got, item);
                end else begin
                    check({name, " unexpected start"}, 1'b1, 1'b0);
                end
                if (cur_edge == skip_edge) begin
                    done_cyc  = -1;
                    exp_start = cyc + TIMEOUT + 2;
                end else begin
                    done_cyc  = cyc + 3;
                    exp_start = cyc + 5;
                    if (cur_edge < 9) exp_ok[cur_edge] = 1'b1;
                end
                if (cur_edge == early_edge) bus.line_done = 1'b1;
            end
            if (cyc == done_cyc) bus.line_done = 1'b1;
            if (cur_edge == geo_edge && cyc == cur_start + 1) begin
                bus.geo_valid = 1'b1;
                bus.geo_xline = 11'd200;
                bus.geo_xdiag = 11'd50;
                bus.geo_ydiag = 10'd90;
                m_pend_xl = 11'd200;
            end
            if (cur_edge == fs_edge && cyc == cur_start + 1) begin
                bus.frame_start = 1'b1;
                exp_over = 1;
            end
            if (cur_edge == rst_edge && cyc == cur_start + 1) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({name, " async reset"});
                model_reset();
                aborted = 1;
                finished = 1;
            end
            if (!aborted && bus.frame_done) begin
                n_fd++;
                fd_cyc = cyc;
                check({name, " frame_done cycle"}, cyc, exp_start);
                check({name, " edges_ok"}, bus.edges_ok, exp_ok);
                check({name, " timeout_err"}, bus.timeout_err, (skip_edge >= 0));
                check({name, " overrun"}, bus.overrun, exp_over);
            end
            if (fd_cyc >= 0 && cyc == fd_cyc + 1) begin
                check({name, " busy falls"}, {bus.busy, bus.frame_done}, 2'b00);
                finished = 1;
            end
        end
        bus.line_done = 1'b0;
        bus.frame_start = 1'b0;
        bus.geo_valid = 1'b0;
        if (!finished) check({name, " frame ends within bound"}, 1'b0, 1'b1);
        if (aborted) begin
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            check({name, " single frame_done"}, n_fd, 1);
            check({name, " all edges issued"}, cur_edge, 8);
            check({name, " scoreboard drained"}, sb.size(), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.geo_valid   = 1'b0;
        bus.geo_xline   = 11'd0;
        bus.geo_xdiag   = 11'd0;
        bus.geo_ydiag   = 10'd0;
        bus.line_done   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_check("post reset", 4);

        run_frame("default", -1, -1, -1, -1, -1);
        check("default e0", obs_item[0], {4'd0, 11'd400, 10'd200, 11'd520, 10'd200});
        check("default e2", obs_item[2], {4'd2, 11'd570, 10'd290, 11'd520, 10'd380});
        check("default e8", obs_item[8], {4'd8, 11'd450, 10'd290, 11'd570, 10'd290});
        idle_check("after default", 3);

        run_frame("timeout", 2, -1, -1, -1, -1);
        idle_check("after timeout", 3);
        check("timeout hold edges_ok", bus.edges_ok, 9'h1FB);
        check("timeout hold err", bus.timeout_err, 1'b1);

        run_frame("geo+early", -1, 4, -1, 0, -1);
        check("geo frame V1 kept", obs_item[1][45:21], {4'd1, 11'd520, 10'd200});
        check("early done edges_ok", bus.edges_ok, 9'h1FF);

        run_frame("overrun", -1, -1, 5, -1, -1);
        check("new geo e0", obs_item[0], {4'd0, 11'd400, 10'd200, 11'd600, 10'd200});
        idle_check("after overrun", 3);
        check("overrun holds", bus.overrun, 1'b1);

        run_frame("reset mid", -1, -1, -1, -1, 6);
        idle_check("after mid reset", 6);

        run_frame("init again", -1, -1, -1, -1, -1);
        check("init geo e0", obs_item[0], {4'd0, 11'd400, 10'd200, 11'd520, 10'd200});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cube_edge_scheduler.md
# cube_edge_scheduler

Sequences the nine edges of the isometric cube through one shared LineCUBE-style line engine, once per frame. It holds the cube geometry, derives the seven vertices, and issues each edge to the engine with a start/done handshake. It sits between the frame timing (vertical-blank pulse) and the line engine, replacing nine free-running per-edge engines. It reports per-edge completion and timeout/overrun status.

## Interface
- X_OFFSET, 11'd400: x of vertex 0
- Y_OFFSET, 10'd200: y of vertex 0
- XLINE_INIT, 11'd120: reset value of edge-length geometry
- XDIAG_INIT, 11'd50: reset value of diagonal x span
- YDIAG_INIT, 10'd90: reset value of diagonal y span
- TIMEOUT, 2048: max WAIT cycles per edge

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- frame_start  in  1  one-cycle pulse at vertical blank
- geo_valid  in  1  load geo_* into pending geometry
- geo_xline  in  11  pending x edge length
- geo_xdiag  in  11  pending diagonal x span
- geo_ydiag  in  10  pending diagonal y span
- line_start  out  1  one-cycle start pulse to engine
- line_x0, line_x1  out  11  edge endpoints x
- line_y0, line_y1  out  10  edge endpoints y
- line_done  in  1  engine completion pulse
- edge_id  out  4  index of edge being issued (0..8)
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last edge
- edges_ok  out  9  bit i set when edge i completed with done
- timeout_err  out  1  sticky: some edge timed out this frame
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- Vertices, computed in LOAD from the active geometry (XO/YO = offsets, XL/XD/YD):
  - V0 = (XO, YO)
  - V1 = (XO+XL, YO)
  - V2 = (XO+XL+XD, YO+YD)
  - V3 = (XO+XL, YO+2YD)
  - V4 = (XO, YO+2YD)
  - V5 = (XO−XD, YO+YD)
  - V6 = (XO+XD, YO+YD)
- Vertex arithmetic is unsigned, truncated modulo 2^11 (x) and 2^10 (y); no saturation.
- Edge order and endpoints (start → end): 0:V0→V1, 1:V1→V2, 2:V2→V3, 3:V3→V4, 4:V5→V4, 5:V0→V5, 6:V0→V6, 7:V6→V4, 8:V6→V2.
- Pending geometry:
  - geo_valid captures geo_* into the pending registers in any state.
  - LOAD copies pending into active using the pending value as registered at the start of that cycle, so a geo_valid in the LOAD cycle applies to the next frame.
- FSM states and transitions:
  - IDLE: on frame_start → LOAD.
  - LOAD: clear edges_ok, timeout_err, overrun; latch active geometry and vertices; edge index := 0 → ISSUE.
  - ISSUE: line_start=1; endpoints driven → WAIT; wait counter := 0.
  - WAIT, line_done=1: set edges_ok[idx] → NEXT.
  - WAIT, counter reaches TIMEOUT−1 without done: set timeout_err; edges_ok[idx] stays 0 → NEXT.
  - NEXT: idx<8 → idx+1, ISSUE; idx=8 → DONE.
  - DONE: frame_done=1 → IDLE.
- line_done is ignored outside WAIT, including in the ISSUE cycle.
- frame_start outside IDLE is ignored and sets overrun; overrun clears only in the next LOAD.
- edges_ok and timeout_err hold after DONE until the next LOAD.

## Timing
- Reset (asynchronous assert):
  - all outputs are 0; state is IDLE; edge_id is 0.
  - pending and active geometry take the *_INIT values.
- Reset mid-frame aborts the frame. After release, nothing is issued until a new frame_start.
- frame_start high at cycle T (in IDLE): LOAD at T+1, line_start with edge 0 at T+2.
- line_x0/y0/x1/y1 and edge_id are registered. They are valid in the ISSUE cycle and held stable until the next ISSUE, so the engine may sample them at any time.
- line_done at cycle D: NEXT at D+1, line_start of the next edge at D+2.
- Per-edge overhead is 2 cycles plus engine latency.
- For the last edge, done at D gives frame_done at D+2 and IDLE at D+3.
- A timeout behaves as a done at the cycle where the counter hits TIMEOUT−1.
- busy rises at T+1 and falls with the IDLE entry.

## Test plan
- Default geometry, engine returns done 3 cycles after each start:
  - edge 0 drives (400,200)→(520,200); edge 2 drives (570,290)→(520,380); edge 8 drives (450,290)→(570,290).
  - frame_done occurs exactly once; edges_ok=0x1FF; timeout_err=0.
- Engine never answers edge 2:
  - edge 3 is issued TIMEOUT+2 cycles after edge 2's start.
  - timeout_err=1; final edges_ok=0x1FB.
  - next frame_start clears both flags in LOAD.
- geo_valid with xline=200 during WAIT of edge 4:
  - the current frame keeps V1=(520,200).
  - next frame edge 0 drives (400,200)→(600,200).
- frame_start pulsed while busy at edge 5:
  - overrun=1; the frame completes normally with a single frame_done.
  - overrun clears at the next accepted LOAD.
- line_done asserted in the same cycle as line_start: ignored. A later done is accepted, and edges_ok holds only one bit per edge.
- reset asserted during WAIT of edge 6:
  - outputs are 0 immediately; no line_start after release.
  - the next frame_start restarts at edge 0 with INIT geometry.
